// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results
// registered and held until the next accepted division completes.
module div32_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dvd_q;   // captured dividend, stable until the next start
   logic [WIDTH-1:0] dvs_q;   // captured divisor, stable until the next start
   logic [WIDTH-1:0] work_q;  // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] rem_q;   // partial remainder

   logic [WIDTH:0]   shifted;
   logic             borrow;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] work_next;

   // Trial subtraction on the (WIDTH+1)-bit shifted remainder. When the top
   // bit is set the value already exceeds any divisor, so no borrow.
   always_comb begin
      shifted   = {rem_q, work_q[WIDTH-1]};
      borrow    = ~shifted[WIDTH] & (shifted[WIDTH-1:0] < dvs_q);
      diff      = shifted[WIDTH-1:0] - dvs_q;
      rem_next  = borrow ? shifted[WIDTH-1:0] : diff;
      work_next = {work_q[WIDTH-2:0], ~borrow};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         work_q      <= '0;
         rem_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_q       <= dividend;
                  dvs_q       <= divisor;
                  work_q      <= dividend;
                  rem_q       <= '0;
                  count       <= '0;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  state       <= RUN;
               end
            end
            RUN: begin
               // A zero divisor spends a single RUN cycle so its fixed
               // results reach the outputs one edge after acceptance.
               if (dvs_q == '0) begin
                  quotient    <= '1;
                  remainder   <= dvd_q;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  work_q <= work_next;
                  rem_q  <= rem_next;
                  count  <= count + 1'b1;
                  if (count == LAST) begin
                     quotient  <= work_next;
                     remainder <= rem_next;
                     done      <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: directed vector table, hand-built corner sequences and
// a back-to-back random run checked against an arithmetic reference.
module tb_div32_seq;

   localparam int W      = 32;
   localparam int N_RAND = 1500;
   localparam int BUDGET = 40;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   div32_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [2*W:0] exp_q[$];   // {div_by_zero, quotient, remainder}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic, with the fixed divide-by-zero convention.
   function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return {1'b1, {W{1'b1}}, a};
      return {1'b0, a / b, a % b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One start pulse, then wait for done. lat = edges after the start edge.
   task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n, output logic seen);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      tick();
      start  = 1'b0;
      lat    = 0;
      busy_n = busy ? 1 : 0;
      seen   = 1'b0;
      while (lat < BUDGET) begin
         tick();
         lat++;
         if (busy) busy_n++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   vec_t tbl[8];

   initial begin
      int           lat;
      int           busy_n;
      logic         seen;
      int           ndone;
      int           gap;
      int           dones;
      bit           first;
      logic [2*W:0] e;
      logic [W-1:0] a;
      logic [W-1:0] b;

      tbl[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,    dz: 1'b0, lat: 32};
      tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0,    dz: 1'b0, lat: 32};
      tbl[2] = '{a: 32'd5,          b: 32'hFFFF_FFFF,  q: 32'd0,          r: 32'd5,    dz: 1'b0, lat: 32};
      tbl[3] = '{a: 32'd1234,       b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd1234, dz: 1'b1, lat: 1};
      tbl[4] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,    dz: 1'b0, lat: 32};
      tbl[5] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,    dz: 1'b0, lat: 32};
      tbl[6] = '{a: 32'd7,          b: 32'd100,        q: 32'd0,          r: 32'd7,    dz: 1'b0, lat: 32};
      tbl[7] = '{a: 32'h8000_0000,  b: 32'd3,          q: 32'h2AAA_AAAA,  r: 32'd2,    dz: 1'b0, lat: 32};

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_quotient", quotient, 0);
      check("rst_remainder", remainder, 0);
      check("rst_dbz", div_by_zero, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         run_one(tbl[i].a, tbl[i].b, lat, busy_n, seen);
         check($sformatf("v%0d_done_seen", i), seen, 1);
         check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
         check($sformatf("v%0d_busy_cycles", i), busy_n, tbl[i].lat + 1);
         check($sformatf("v%0d_quotient", i), quotient, tbl[i].q);
         check($sformatf("v%0d_remainder", i), remainder, tbl[i].r);
         check($sformatf("v%0d_dbz", i), div_by_zero, tbl[i].dz);
         tick();
         check($sformatf("v%0d_done_pulse", i), done, 0);
         check($sformatf("v%0d_busy_after", i), busy, 0);
         check($sformatf("v%0d_hold_quotient", i), quotient, tbl[i].q);
      end

      // start re-asserted mid-RUN with other operands must be ignored
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      lat   = 0;
      seen  = 1'b0;
      for (int c = 1; c <= BUDGET; c++) begin
         if (c == 5 || c == 20) begin
            start    = 1'b1;
            dividend = $urandom;
            divisor  = W'($urandom_range(1, 9));
         end
         tick();
         start = 1'b0;
         if (done) begin
            lat  = c;
            seen = 1'b1;
            break;
         end
      end
      check("ignore_done_seen", seen, 1);
      check("ignore_latency", lat, 32);
      check("ignore_quotient", quotient, 14);
      check("ignore_remainder", remainder, 2);
      tick();

      // Reset in the middle of RUN aborts with no done pulse
      dividend = 32'd100;
      divisor  = 32'd7;
      start    = 1'b1;
      tick();
      start = 1'b0;
      repeat (16) tick();
      #2 rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_quotient", quotient, 0);
      check("abort_remainder", remainder, 0);
      check("abort_dbz", div_by_zero, 0);
      #2 rst = 1'b0;
      dones = 0;
      repeat (BUDGET) begin
         tick();
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      run_one(32'd9, 32'd3, lat, busy_n, seen);
      check("post_rst_done_seen", seen, 1);
      check("post_rst_latency", lat, 32);
      check("post_rst_quotient", quotient, 3);
      check("post_rst_remainder", remainder, 0);
      tick();

      // Back-to-back random divisions with start held high
      a = $urandom;
      b = $urandom_range(1, 1000);
      dividend = a;
      divisor  = b;
      exp_q.push_back(model(a, b));
      start = 1'b1;
      ndone = 0;
      gap   = 0;
      first = 1'b1;
      while (ndone < N_RAND) begin
         tick();
         gap++;
         if (gap > BUDGET) begin
            n_vec++;
            n_err++;
            $display("FAIL rand_timeout: no done within %0d cycles after result %0d", BUDGET, ndone);
            break;
         end
         if (done) begin
            e = exp_q.pop_front();
            check("rand_quotient", quotient, e[2*W-1:W]);
            check("rand_remainder", remainder, e[W-1:0]);
            check("rand_dbz", div_by_zero, e[2*W]);
            if (!first) check("rand_spacing", gap, e[2*W] ? 3 : 34);
            first = 1'b0;
            gap   = 0;
            ndone++;
            if (ndone < N_RAND) begin
               a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 5000)) : $urandom;
               case ($urandom_range(0, 9))
                  0:       b = '0;
                  1, 2, 3: b = W'($urandom_range(1, 255));
                  4:       b = '1;
                  default: b = $urandom;
               endcase
               dividend = a;
               divisor  = b;
               exp_q.push_back(model(a, b));
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      repeat (3) tick();
      check("final_idle_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
